// File: rtl/conv_tile_scheduler_if.sv
// Control/engine bundle for the conv tile scheduler.
// master: scheduler side; slave: host + engine side.
interface conv_tile_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int XW     = 2,
  parameter int YW     = 2,
  parameter int OW     = 2
);
  logic              start;
  logic              abort;
  logic              conv_ready;
  logic              conv_valid;
  logic              conv_tile_done;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] wt_base;
  logic [XW-1:0]     tile_x;
  logic [YW-1:0]     tile_y;
  logic [OW-1:0]     ofm;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, conv_valid, conv_tile_done,
    output conv_ready, rd_base, wr_base, wt_base,
    output tile_x, tile_y, ofm, busy, done, err
  );

  modport slave (
    output start, abort, conv_valid, conv_tile_done,
    input  conv_ready, rd_base, wr_base, wt_base,
    input  tile_x, tile_y, ofm, busy, done, err
  );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Walks ofm/tile_y/tile_x, issues one conv_ready per tile, waits valid+done.
// Ports: clk, rst_n (async low), bus (master: start/abort in, bases/idx/status out).
module conv_tile_scheduler #(
  parameter int          NOF       = 4,
  parameter int          TILES_Y   = 4,
  parameter int          TILES_X   = 4,
  parameter logic [31:0] RD_STRIDE = 32'h2000,
  parameter logic [31:0] WR_STRIDE = 32'h0800,
  parameter logic [31:0] WT_STRIDE = 32'h0040,
  parameter int          ADDR_W    = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  conv_tile_scheduler_if.master bus
);

  localparam int XW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int YW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
  localparam int OW = (NOF > 1) ? $clog2(NOF) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(TILES_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(TILES_Y - 1);
  localparam logic [OW-1:0] O_LAST = OW'(NOF - 1);

  localparam logic [ADDR_W-1:0] RD_S = ADDR_W'(RD_STRIDE);
  localparam logic [ADDR_W-1:0] WR_S = ADDR_W'(WR_STRIDE);
  localparam logic [ADDR_W-1:0] WT_S = ADDR_W'(WT_STRIDE);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_VALID,
    WAIT_DONE,
    ADVANCE
  } state_t;

  state_t            state;
  logic              conv_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] wt_base;
  logic [XW-1:0]     tile_x;
  logic [YW-1:0]     tile_y;
  logic [OW-1:0]     ofm;

  logic x_wrap;
  logic y_wrap;
  logic is_last;

  assign x_wrap  = (tile_x == X_LAST);
  assign y_wrap  = (tile_y == Y_LAST);
  assign is_last = x_wrap && y_wrap && (ofm == O_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      conv_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rd_base    <= '0;
      wr_base    <= '0;
      wt_base    <= '0;
      tile_x     <= '0;
      tile_y     <= '0;
      ofm        <= '0;
    end else begin
      conv_ready <= 1'b0;
      done       <= 1'b0;
      if (bus.abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        rd_base <= '0;
        wr_base <= '0;
        wt_base <= '0;
        tile_x  <= '0;
        tile_y  <= '0;
        ofm     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state      <= ISSUE;
              conv_ready <= 1'b1;
              busy       <= 1'b1;
              err        <= 1'b0;
              rd_base    <= '0;
              wr_base    <= '0;
              wt_base    <= '0;
              tile_x     <= '0;
              tile_y     <= '0;
              ofm        <= '0;
            end
          end
          ISSUE: begin
            state <= WAIT_VALID;
          end
          WAIT_VALID: begin
            // tile_done without valid: flag it and skip the tile
            if (bus.conv_tile_done) begin
              state <= ADVANCE;
              done  <= is_last;
              if (!bus.conv_valid) err <= 1'b1;
            end else if (bus.conv_valid) begin
              state <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (bus.conv_valid) err <= 1'b1;
            if (bus.conv_tile_done) begin
              state <= ADVANCE;
              done  <= is_last;
            end
          end
          ADVANCE: begin
            if (is_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= ISSUE;
              conv_ready <= 1'b1;
              wr_base    <= wr_base + WR_S;
              if (!x_wrap) begin
                tile_x  <= tile_x + XW'(1);
                rd_base <= rd_base + RD_S;
              end else begin
                tile_x <= '0;
                if (!y_wrap) begin
                  tile_y  <= tile_y + YW'(1);
                  rd_base <= rd_base + RD_S;
                end else begin
                  tile_y  <= '0;
                  ofm     <= ofm + OW'(1);
                  rd_base <= '0;
                  wt_base <= wt_base + WT_S;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.conv_ready = conv_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.rd_base    = rd_base;
  assign bus.wr_base    = wr_base;
  assign bus.wt_base    = wt_base;
  assign bus.tile_x     = tile_x;
  assign bus.tile_y     = tile_y;
  assign bus.ofm        = ofm;

endmodule
